// File: rtl/reg_file_pkg.sv
// Shared constants, lane-count helper and legacy register map for the register bank.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int SP_STEP_DEF  = 2;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Legacy 8-register map; REG_SP is the default stack-pointer slot.
  typedef enum logic [2:0] {
    REG_AX = 3'd0,
    REG_CX = 3'd1,
    REG_DX = 3'd2,
    REG_BX = 3'd3,
    REG_SP = 3'd4,
    REG_BP = 3'd5,
    REG_SI = 3'd6,
    REG_DI = 3'd7
  } legacy_reg_e;

endpackage

// File: rtl/reg_file_bank_if.sv
// Decode/control <-> register bank bus: write port, SP adjust, two read ports.
interface reg_file_bank_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) ();
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int LANES  = lane_count(DATA_W);

  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [LANES-1:0]  WBE;
  logic [DATA_W-1:0] WDATA;
  logic              WREPL;
  logic              SP_PUSH;
  logic              SP_POP;
  logic [ADDR_W-1:0] RADDR_A;
  logic [DATA_W-1:0] RDATA_A;
  logic [ADDR_W-1:0] RADDR_B;
  logic [DATA_W-1:0] RDATA_B;
  logic [DATA_W-1:0] SP;
  logic              WERR;

  modport master (
    output WE, WADDR, WBE, WDATA, WREPL, SP_PUSH, SP_POP, RADDR_A, RADDR_B,
    input  RDATA_A, RDATA_B, SP, WERR
  );

  modport slave (
    input  WE, WADDR, WBE, WDATA, WREPL, SP_PUSH, SP_POP, RADDR_A, RADDR_B,
    output RDATA_A, RDATA_B, SP, WERR
  );

endinterface

// File: rtl/reg_lane_merge.sv
// Byte-lane merge of write data into an existing register value.
module reg_lane_merge
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]               old_val,
  input  logic [DATA_W-1:0]               wdata,
  input  logic [lane_count(DATA_W)-1:0]   wbe,
  input  logic                            wrepl,
  output logic [DATA_W-1:0]               merged
);
  localparam int LANES = lane_count(DATA_W);

  // With wrepl the low byte is broadcast, replacing the old high/low byte select.
  always_comb begin
    merged = old_val;
    for (int i = 0; i < LANES; i++) begin
      if (wbe[i]) begin
        merged[8*i +: 8] = wrepl ? wdata[7:0] : wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_file_bank.sv
// Parametrised register bank with byte-lane writes, two read ports and SP push/pop.
// Optional same-cycle forwarding to read ports and SP when REG_FILE_BYPASS_EN is defined.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int SP_IDX   = int'(REG_SP),
  parameter int SP_STEP  = SP_STEP_DEF,
  parameter int SP_RST   = 0
) (
  input  logic            CLK,
  input  logic            RST,
  reg_file_bank_if.slave  bus
);
  localparam logic [ADDR_W-1:0] SP_ADDR    = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [DATA_W-1:0] SP_STEP_W  = DATA_W'(SP_STEP);
  localparam logic [DATA_W-1:0] SP_RST_W   = DATA_W'(SP_RST);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              werr_q;
  logic              werr_d;

  logic              waddr_ok;
  logic              wr_valid;
  logic              wr_sp;
  logic              sp_adj;
  logic              sp_fwd;
  logic              sp_conflict;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_a_cur;
  logic [DATA_W-1:0] rd_b_cur;
  logic [DATA_W-1:0] sp_cur;
  logic [DATA_W-1:0] sp_adjusted;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] sp_out;

  // Loop-based lookup so out-of-range indices cleanly yield 0.
  always_comb begin
    wr_old   = '0;
    rd_a_cur = '0;
    rd_b_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.WADDR == ADDR_W'(i))   wr_old   = regs_q[i];
      if (bus.RADDR_A == ADDR_W'(i)) rd_a_cur = regs_q[i];
      if (bus.RADDR_B == ADDR_W'(i)) rd_b_cur = regs_q[i];
    end
  end

  reg_lane_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_val (wr_old),
    .wdata   (bus.WDATA),
    .wbe     (bus.WBE),
    .wrepl   (bus.WREPL),
    .merged  (wr_merged)
  );

  always_comb begin
    waddr_ok    = {1'b0, bus.WADDR} < NUM_REGS_W;
    wr_valid    = bus.WE & waddr_ok;
    wr_sp       = wr_valid & (bus.WADDR == SP_ADDR);
    sp_conflict = bus.SP_PUSH & bus.SP_POP;
    sp_adj      = bus.SP_PUSH ^ bus.SP_POP;
    // An explicit write to SP discards the adjust entirely.
    sp_fwd      = sp_adj & ~wr_sp;
    sp_cur      = regs_q[SP_IDX];
    sp_adjusted = bus.SP_PUSH ? (sp_cur - SP_STEP_W) : (sp_cur + SP_STEP_W);
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_valid && (bus.WADDR == ADDR_W'(i))) regs_d[i] = wr_merged;
    end
    if (sp_fwd) regs_d[SP_IDX] = sp_adjusted;
    werr_d = werr_q | (bus.WE & ~waddr_ok) | sp_conflict;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST_W : '0;
      end
      werr_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      werr_q <= werr_d;
    end
  end

  always_comb begin
    rdata_a = rd_a_cur;
    rdata_b = rd_b_cur;
    sp_out  = sp_cur;
`ifdef REG_FILE_BYPASS_EN
    if (wr_valid && (bus.RADDR_A == bus.WADDR))  rdata_a = wr_merged;
    else if (sp_fwd && (bus.RADDR_A == SP_ADDR)) rdata_a = sp_adjusted;
    if (wr_valid && (bus.RADDR_B == bus.WADDR))  rdata_b = wr_merged;
    else if (sp_fwd && (bus.RADDR_B == SP_ADDR)) rdata_b = sp_adjusted;
    if (wr_sp)       sp_out = wr_merged;
    else if (sp_fwd) sp_out = sp_adjusted;
`endif
  end

  assign bus.RDATA_A = rdata_a;
  assign bus.RDATA_B = rdata_b;
  assign bus.SP      = sp_out;
  assign bus.WERR    = werr_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Bench: an 8-register and a 6-register bank driven by identical stimulus, each checked against an array model.
module tb_reg_file_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, wrepl, push, pop;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [1:0]  wbe;
  logic [15:0] wdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [2][8];
  logic        werr_m [2];

  always #5 clk = ~clk;

  reg_file_bank_if #(.DATA_W(16), .NUM_REGS(8)) bus8 ();
  reg_file_bank_if #(.DATA_W(16), .NUM_REGS(6)) bus6 ();

  assign bus8.WE = we;        assign bus6.WE = we;
  assign bus8.WADDR = waddr;  assign bus6.WADDR = waddr;
  assign bus8.WBE = wbe;      assign bus6.WBE = wbe;
  assign bus8.WDATA = wdata;  assign bus6.WDATA = wdata;
  assign bus8.WREPL = wrepl;  assign bus6.WREPL = wrepl;
  assign bus8.SP_PUSH = push; assign bus6.SP_PUSH = push;
  assign bus8.SP_POP = pop;   assign bus6.SP_POP = pop;
  assign bus8.RADDR_A = raddr_a; assign bus6.RADDR_A = raddr_a;
  assign bus8.RADDR_B = raddr_b; assign bus6.RADDR_B = raddr_b;

  reg_file_bank #(.DATA_W(16), .NUM_REGS(8)) dut8 (.CLK(clk), .RST(rst), .bus(bus8));
  reg_file_bank #(.DATA_W(16), .NUM_REGS(6)) dut6 (.CLK(clk), .RST(rst), .bus(bus6));

  function automatic int n_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] merge_val(input logic [15:0] old);
    logic [15:0] r;
    r = old;
    if (wbe[0]) r[7:0]  = wdata[7:0];
    if (wbe[1]) r[15:8] = wrepl ? wdata[7:0] : wdata[15:8];
    return r;
  endfunction

  function automatic logic write_legal(input int k);
    return we && (int'(waddr) < n_of(k));
  endfunction

  function automatic logic [15:0] exp_rd(input int k, input logic [2:0] a);
    if (int'(a) >= n_of(k)) return 16'h0000;
`ifdef REG_FILE_BYPASS_EN
    if (write_legal(k) && a == waddr) return merge_val(mem[k][a]);
    if ((push != pop) && !(write_legal(k) && waddr == 3'd4) && a == 3'd4)
      return pop ? mem[k][4] + 16'd2 : mem[k][4] - 16'd2;
`endif
    return mem[k][a];
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("n8_rdata_a", bus8.RDATA_A, exp_rd(0, raddr_a));
    check("n8_rdata_b", bus8.RDATA_B, exp_rd(0, raddr_b));
    check("n8_sp",      bus8.SP,      exp_rd(0, 3'd4));
    check("n8_werr",    {15'd0, bus8.WERR}, {15'd0, werr_m[0]});
    check("n6_rdata_a", bus6.RDATA_A, exp_rd(1, raddr_a));
    check("n6_rdata_b", bus6.RDATA_B, exp_rd(1, raddr_b));
    check("n6_sp",      bus6.SP,      exp_rd(1, 3'd4));
    check("n6_werr",    {15'd0, bus6.WERR}, {15'd0, werr_m[1]});
  endtask

  task automatic update_model();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] nxt [8];
      if (!rst) begin
        for (int i = 0; i < 8; i++) mem[k][i] = 16'h0000;
        werr_m[k] = 1'b0;
      end else begin
        for (int i = 0; i < 8; i++) nxt[i] = mem[k][i];
        if (we && !write_legal(k)) werr_m[k] = 1'b1;
        if (push && pop) werr_m[k] = 1'b1;
        if (write_legal(k)) nxt[waddr] = merge_val(mem[k][waddr]);
        if ((push != pop) && !(write_legal(k) && waddr == 3'd4))
          nxt[4] = pop ? mem[k][4] + 16'd2 : mem[k][4] - 16'd2;
        for (int i = 0; i < 8; i++) mem[k][i] = nxt[i];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wbe = 2'b00; wdata = 16'h0000; wrepl = 1'b0;
    push = 1'b0; pop = 1'b0; waddr = 3'd0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = 16'h0000;
      werr_m[k] = 1'b0;
    end
    idle();
    raddr_a = 3'd0; raddr_b = 3'd0;
    rst = 1'b0; we = 1'b1; wbe = 2'b11; wdata = 16'hFFFF;
    tick(); tick();
    rst = 1'b1; idle();

    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i);
      step();
      check("rst_reg_zero", bus8.RDATA_A, 16'h0000);
      tick();
    end
    step();
    check("rst_sp", bus8.SP, 16'h0000);
    check("rst_werr", {15'd0, bus8.WERR}, 16'h0000);
    tick();

    raddr_a = 3'd0;
    we = 1'b1; waddr = 3'd0; wbe = 2'b11; wdata = 16'hA55A; wrepl = 1'b0;
    step(); tick(); idle(); step();
    check("lane_full", bus8.RDATA_A, 16'hA55A);
    tick();
    we = 1'b1; waddr = 3'd0; wbe = 2'b10; wdata = 16'h00FF; wrepl = 1'b1;
    step(); tick(); idle(); step();
    check("lane_repl_hi", bus8.RDATA_A, 16'hFF5A);
    tick();

    push = 1'b1; step(); tick(); idle(); step();
    check("sp_push_wrap", bus8.SP, 16'hFFFE);
    tick();
    pop = 1'b1; step(); tick(); idle(); step();
    check("sp_pop_wrap", bus8.SP, 16'h0000);
    tick();

    push = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 16'h1234; wbe = 2'b11;
    step(); tick(); idle(); step();
    check("sp_write_wins", bus8.SP, 16'h1234);
    check("sp_write_werr", {15'd0, bus8.WERR}, 16'h0000);
    tick();
    push = 1'b1; pop = 1'b1; step(); tick(); idle(); step();
    check("sp_both_hold", bus8.SP, 16'h1234);
    check("sp_both_werr", {15'd0, bus8.WERR}, 16'h0001);
    tick();

    rst = 1'b0; tick(); rst = 1'b1;
    we = 1'b1; waddr = 3'd7; wdata = 16'hDEAD; wbe = 2'b11;
    step(); tick(); idle(); step();
    check("oor_werr6", {15'd0, bus6.WERR}, 16'h0001);
    check("oor_werr8", {15'd0, bus8.WERR}, 16'h0000);
    tick();
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      step();
      check("oor_no_change", bus6.RDATA_A, 16'h0000);
      tick();
    end
    step();
    check("oor_sticky", {15'd0, bus6.WERR}, 16'h0001);
    tick();
    rst = 1'b0; tick(); rst = 1'b1; step();
    check("oor_cleared", {15'd0, bus6.WERR}, 16'h0000);
    tick();

    we = 1'b1; waddr = 3'd3; wdata = 16'h1200; wbe = 2'b11;
    step(); tick();
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; wbe = 2'b01; raddr_a = 3'd3;
    step();
`ifdef REG_FILE_BYPASS_EN
    check("bypass_same_cycle", bus8.RDATA_A, 16'h12EF);
`else
    check("bypass_same_cycle", bus8.RDATA_A, 16'h1200);
`endif
    tick(); idle(); step();
    check("bypass_after", bus8.RDATA_A, 16'h12EF);
    tick();

    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(63) != 0);
      we      = $urandom_range(1);
      waddr   = 3'($urandom_range(7));
      wbe     = 2'($urandom_range(3));
      wdata   = 16'($urandom);
      wrepl   = ($urandom_range(3) == 0);
      push    = ($urandom_range(3) == 0);
      pop     = ($urandom_range(3) == 0);
      raddr_a = ($urandom_range(2) == 0) ? waddr : 3'($urandom_range(7));
      raddr_b = ($urandom_range(2) == 0) ? 3'd4  : 3'($urandom_range(7));
      step();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
